// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction-fetch, load/store and byte-wide memory signals
// shared between mem_arbiter (slave) and the pipeline/memory side (master).
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_abort;
    logic              if_done;
    logic [DATA_W-1:0] if_data;

    logic              ls_req;
    logic              ls_we;
    logic [1:0]        ls_len;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_done;
    logic [DATA_W-1:0] ls_rdata;

    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;

    modport master (
        output if_req, if_addr, if_abort,
        input  if_done, if_data,
        output ls_req, ls_we, ls_len, ls_addr, ls_wdata,
        input  ls_done, ls_rdata,
        output mem_din,
        input  mem_dout, mem_a, mem_wr
    );

    modport slave (
        input  if_req, if_addr, if_abort,
        output if_done, if_data,
        input  ls_req, ls_we, ls_len, ls_addr, ls_wdata,
        output ls_done, ls_rdata,
        input  mem_din,
        output mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial memory controller: shares one 8-bit RAM/IO bus between instruction
// fetch and load/store, sequencing little-endian multi-byte transfers (LS first).
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_rdy,
    mem_arbiter_if.slave  io_bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_cnt;
    logic [2:0]        r_n;
    logic              r_isLs;
    logic [ADDR_W-1:0] r_base;
    logic [DATA_W-1:0] r_buf;
    logic [DATA_W-1:0] r_ifData;
    logic [DATA_W-1:0] r_lsRdata;

    logic [2:0]        w_lsN;
    logic              w_abort;
    logic [1:0]        w_idx;
    logic [DATA_W-1:0] w_word;
    logic [ADDR_W-1:0] w_memA;
    logic [7:0]        w_memDout;
    logic              w_memWr;
    logic              w_ifDone;
    logic              w_lsDone;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else if (i_rdy) begin
            r_state <= w_next;
        end
    end

    // During a freeze in READ the previous address is replayed so the byte
    // awaiting capture is still on mem_din when the bus resumes.
    always_comb begin
        w_next    = r_state;
        w_memA    = '0;
        w_memDout = 8'h00;
        w_memWr   = 1'b0;
        w_ifDone  = 1'b0;
        w_lsDone  = 1'b0;
        w_abort   = (r_state == READ) && !r_isLs && io_bus.if_abort;
        w_idx     = 2'(r_cnt - 3'd1);
        w_word    = r_buf;
        w_word[{w_idx, 3'b000} +: 8] = io_bus.mem_din;
        case (io_bus.ls_len)
            2'b00:   w_lsN = 3'd1;
            2'b01:   w_lsN = 3'd2;
            default: w_lsN = 3'd4;
        endcase
        case (r_state)
            IDLE: begin
                if (io_bus.ls_req) begin
                    w_next = io_bus.ls_we ? WRITE : READ;
                end else if (io_bus.if_req && !io_bus.if_abort) begin
                    w_next = READ;
                end
            end
            READ: begin
                if (w_abort) begin
                    w_next = IDLE;
                end else if (r_cnt == r_n) begin
                    w_next = DONE;
                end
                if (!i_rdy && r_cnt != 3'd0) begin
                    w_memA = r_base + ADDR_W'(r_cnt - 3'd1);
                end else if (r_cnt < r_n) begin
                    w_memA = r_base + ADDR_W'(r_cnt);
                end
            end
            WRITE: begin
                w_memWr   = i_rdy;
                w_memA    = r_base + ADDR_W'(r_cnt);
                w_memDout = r_buf[{r_cnt[1:0], 3'b000} +: 8];
                if (r_cnt == r_n - 3'd1) begin
                    w_next = DONE;
                end
            end
            default: begin
                w_next   = IDLE;
                w_ifDone = !r_isLs;
                w_lsDone = r_isLs;
            end
        endcase
    end

    // Grant latches the owner's request; read buffers start cleared so bytes
    // beyond the transfer length come out as zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= 3'd0;
            r_n       <= 3'd0;
            r_isLs    <= 1'b0;
            r_base    <= '0;
            r_buf     <= '0;
            r_ifData  <= '0;
            r_lsRdata <= '0;
        end else if (i_rdy) begin
            case (r_state)
                IDLE: begin
                    if (w_next != IDLE) begin
                        r_cnt  <= 3'd0;
                        r_isLs <= io_bus.ls_req;
                        r_base <= io_bus.ls_req ? io_bus.ls_addr : io_bus.if_addr;
                        r_n    <= io_bus.ls_req ? w_lsN : 3'd4;
                        r_buf  <= (io_bus.ls_req && io_bus.ls_we) ? io_bus.ls_wdata : '0;
                    end
                end
                READ: begin
                    if (!w_abort) begin
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt != 3'd0) begin
                            r_buf <= w_word;
                        end
                        if (r_cnt == r_n) begin
                            if (r_isLs) begin
                                r_lsRdata <= w_word;
                            end else begin
                                r_ifData <= w_word;
                            end
                        end
                    end
                end
                WRITE: begin
                    r_cnt <= r_cnt + 3'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign io_bus.if_done  = w_ifDone;
    assign io_bus.if_data  = r_ifData;
    assign io_bus.ls_done  = w_lsDone;
    assign io_bus.ls_rdata = r_lsRdata;
    assign io_bus.mem_a    = w_memA;
    assign io_bus.mem_dout = w_memDout;
    assign io_bus.mem_wr   = w_memWr;
endmodule
